ram_loader_arbiter: RTL and testbench

RAM_LOADER_ARBITER -- requirements
Module: ram_loader_arbiter

---
 rtl/ram_loader_arbiter.sv | 161 ++++++++++++++++
 tb/tb_ram_loader_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader_arbiter.sv
// Shares one RAM port between a CPU and a byte-stream loader. Loader bytes queue in a small FIFO
// and go to RAM in cycles the CPU leaves free. The CPU is held for the whole loader session.
module ram_loader_arbiter #(
  parameter int unsigned RELEASE_CYCLES  = 4,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic        clk7,
  input  logic        rst,
  input  logic        cpu_clken,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_hold,
  input  logic        dl_active,
  input  logic [15:0] dl_addr,
  input  logic [7:0]  dl_data,
  input  logic        dl_wr,
  output logic        dl_ready,
  output logic        dl_overflow,
  output logic [15:0] dl_count,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_rd,
  output logic        ram_wr,
  input  logic [7:0]  ram_dout
);

  localparam int unsigned Depth = 2 ** FIFO_DEPTH_LOG2;
  localparam int unsigned RelW  = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

  typedef logic [FIFO_DEPTH_LOG2-1:0] ptr_t;
  typedef logic [FIFO_DEPTH_LOG2:0]   occ_t;

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StRelease} state_e;

  state_e           state_q, state_d;
  logic [RelW-1:0]  rel_q, rel_d;
  ptr_t             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  occ_t             occ_q, occ_d;
  logic [15:0]      count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      addr_mem [Depth];
  logic [7:0]       data_mem [Depth];

  logic in_load, full, empty, push, drop, pop;

  always_comb begin
    in_load = (state_q == StLoad);
    full    = (occ_q == occ_t'(Depth));
    empty   = (occ_q == '0);
    push    = in_load & dl_wr & ~full;
    drop    = in_load & dl_wr & full;
    // Loader write slot: any queued byte while the CPU is not using the RAM this cycle
    pop     = ((state_q == StLoad) || (state_q == StDrain)) & ~empty & ~cpu_clken;
  end

  always_comb begin
    state_d  = state_q;
    rel_d    = rel_q;
    wr_ptr_d = wr_ptr_q + ptr_t'(push);
    rd_ptr_d = rd_ptr_q + ptr_t'(pop);
    occ_d    = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + occ_t'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - occ_t'(1);
    end
    count_d = count_q + 16'(pop);
    ovf_d   = ovf_q | drop;

    unique case (state_q)
      StIdle: begin
        if (dl_active) begin
          state_d  = StLoad;
          ovf_d    = 1'b0;
          count_d  = '0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          occ_d    = '0;
        end
      end
      StLoad: begin
        if (!dl_active) begin
          if (occ_d != '0) begin
            state_d = StDrain;
          end else begin
            state_d = StRelease;
            rel_d   = RelW'(RELEASE_CYCLES - 1);
          end
        end
      end
      StDrain: begin
        if (dl_active) begin
          state_d = StLoad;
        end else if (occ_d == '0) begin
          state_d = StRelease;
          rel_d   = RelW'(RELEASE_CYCLES - 1);
        end
      end
      StRelease: begin
        if (dl_active) begin
          state_d = StLoad;
        end else if (rel_q == '0) begin
          state_d = StIdle;
        end else begin
          rel_d = rel_q - RelW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk7 or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      rel_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rel_q    <= rel_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk7) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= dl_addr;
      data_mem[wr_ptr_q] <= dl_data;
    end
  end

  always_comb begin
    cpu_hold    = (state_q != StIdle);
    dl_ready    = in_load & ~full;
    dl_overflow = ovf_q;
    dl_count    = count_q;
    cpu_rdata   = ram_dout;
    ram_addr    = cpu_addr;
    ram_din     = cpu_wdata;
    ram_rd      = cpu_rd;
    ram_wr      = cpu_wr & cpu_clken & ~cpu_hold;
    if (pop) begin
      ram_addr = addr_mem[rd_ptr_q];
      ram_din  = data_mem[rd_ptr_q];
      ram_rd   = 1'b0;
      ram_wr   = 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_loader_arbiter.sv
// Directed bench for ram_loader_arbiter: inputs change 1 time unit after the rising edge and
// outputs are checked 1 unit later, well away from the next edge.
module tb_ram_loader_arbiter;

  logic        clk7 = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_clken = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_rdata;
  logic        cpu_hold;
  logic        dl_active = 1'b0;
  logic [15:0] dl_addr = '0;
  logic [7:0]  dl_data = '0;
  logic        dl_wr = 1'b0;
  logic        dl_ready;
  logic        dl_overflow;
  logic [15:0] dl_count;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_rd;
  logic        ram_wr;
  logic [7:0]  ram_dout = '0;

  int n_vec = 0;
  int n_err = 0;

  ram_loader_arbiter dut (
    .clk7        (clk7),
    .rst         (rst),
    .cpu_clken   (cpu_clken),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rd      (cpu_rd),
    .cpu_wr      (cpu_wr),
    .cpu_rdata   (cpu_rdata),
    .cpu_hold    (cpu_hold),
    .dl_active   (dl_active),
    .dl_addr     (dl_addr),
    .dl_data     (dl_data),
    .dl_wr       (dl_wr),
    .dl_ready    (dl_ready),
    .dl_overflow (dl_overflow),
    .dl_count    (dl_count),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_rd      (ram_rd),
    .ram_wr      (ram_wr),
    .ram_dout    (ram_dout)
  );

  always #5 clk7 = ~clk7;

  task automatic cyc();
    @(posedge clk7);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_vec++; if (cpu_hold !== 1'b0) begin n_err++; $display("FAIL rst_hold got %b want 0", cpu_hold); end
    n_vec++; if (dl_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b want 0", dl_ready); end
    n_vec++; if (dl_overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b want 0", dl_overflow); end
    n_vec++; if (dl_count !== 16'h0000) begin n_err++; $display("FAIL rst_count got %h want 0000", dl_count); end
    cyc();
    cyc();
    n_vec++; if (cpu_hold !== 1'b0) begin n_err++; $display("FAIL rst_hold_clk got %b want 0", cpu_hold); end
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    cyc();
    cpu_clken = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'h0300; cpu_wdata = 8'h5A; ram_dout = 8'h3C;
    #1;
    n_vec++; if (ram_wr !== 1'b1) begin n_err++; $display("FAIL pt_wr got %b want 1", ram_wr); end
    n_vec++; if (ram_addr !== 16'h0300) begin n_err++; $display("FAIL pt_addr got %h want 0300", ram_addr); end
    n_vec++; if (ram_din !== 8'h5A) begin n_err++; $display("FAIL pt_din got %h want 5a", ram_din); end
    n_vec++; if (cpu_rdata !== 8'h3C) begin n_err++; $display("FAIL pt_rdata got %h want 3c", cpu_rdata); end
    cyc();
    cpu_wr = 1'b0; cpu_rd = 1'b1;
    #1;
    n_vec++; if (ram_rd !== 1'b1) begin n_err++; $display("FAIL pt_rd got %b want 1", ram_rd); end
    n_vec++; if (ram_wr !== 1'b0) begin n_err++; $display("FAIL pt_rd_wr got %b want 0", ram_wr); end
    cyc();
    cpu_rd = 1'b0; cpu_clken = 1'b0;
  endtask

  task automatic test_single_byte();
    cyc();
    dl_active = 1'b1; cpu_clken = 1'b0;
    #1;
    n_vec++; if (cpu_hold !== 1'b0) begin n_err++; $display("FAIL sb_idle_hold got %b want 0", cpu_hold); end
    cyc();
    dl_wr = 1'b1; dl_addr = 16'h0280; dl_data = 8'hA9;
    #1;
    n_vec++; if (cpu_hold !== 1'b1) begin n_err++; $display("FAIL sb_load_hold got %b want 1", cpu_hold); end
    n_vec++; if (dl_ready !== 1'b1) begin n_err++; $display("FAIL sb_ready got %b want 1", dl_ready); end
    n_vec++; if (ram_wr !== 1'b0) begin n_err++; $display("FAIL sb_empty_wr got %b want 0", ram_wr); end
    cyc();
    dl_wr = 1'b0;
    #1;
    n_vec++; if (ram_wr !== 1'b1) begin n_err++; $display("FAIL sb_wr got %b want 1", ram_wr); end
    n_vec++; if (ram_addr !== 16'h0280) begin n_err++; $display("FAIL sb_addr got %h want 0280", ram_addr); end
    n_vec++; if (ram_din !== 8'hA9) begin n_err++; $display("FAIL sb_din got %h want a9", ram_din); end
    n_vec++; if (ram_rd !== 1'b0) begin n_err++; $display("FAIL sb_rd got %b want 0", ram_rd); end
    cyc();
    dl_active = 1'b0;
    #1;
    n_vec++; if (ram_wr !== 1'b0) begin n_err++; $display("FAIL sb_after_wr got %b want 0", ram_wr); end
    n_vec++; if (dl_count !== 16'h0001) begin n_err++; $display("FAIL sb_count got %h want 0001", dl_count); end
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_vec++; if (cpu_hold !== 1'b1) begin n_err++; $display("FAIL sb_release_hold[%0d] got %b want 1", i, cpu_hold); end
    end
    cyc();
    n_vec++; if (cpu_hold !== 1'b0) begin n_err++; $display("FAIL sb_released got %b want 0", cpu_hold); end
  endtask

  task automatic test_slot_blocking();
    cyc();
    dl_active = 1'b1; cpu_clken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      dl_wr = 1'b1; dl_addr = 16'(16'h1000 + i); dl_data = 8'(8'h10 + i);
      cpu_wr = 1'b1; cpu_addr = 16'h0300;
      #1;
      n_vec++; if (dl_ready !== 1'b1) begin n_err++; $display("FAIL blk_ready[%0d] got %b want 1", i, dl_ready); end
      n_vec++; if (ram_wr !== 1'b0) begin n_err++; $display("FAIL blk_cpu_wr[%0d] got %b want 0", i, ram_wr); end
      if (i == 0) begin
        n_vec++; if (dl_count !== 16'h0000) begin n_err++; $display("FAIL blk_count_clr got %h want 0000", dl_count); end
      end
    end
    cyc();
    dl_addr = 16'h1004; dl_data = 8'h14;
    #1;
    n_vec++; if (dl_ready !== 1'b0) begin n_err++; $display("FAIL blk_full_ready got %b want 0", dl_ready); end
    n_vec++; if (ram_wr !== 1'b0) begin n_err++; $display("FAIL blk_full_wr got %b want 0", ram_wr); end
    n_vec++; if (dl_overflow !== 1'b0) begin n_err++; $display("FAIL blk_ovf_pre got %b want 0", dl_overflow); end
    cyc();
    dl_wr = 1'b0; cpu_wr = 1'b0; cpu_clken = 1'b0;
    #1;
    n_vec++; if (dl_overflow !== 1'b1) begin n_err++; $display("FAIL blk_ovf got %b want 1", dl_overflow); end
    for (int i = 0; i < 4; i++) begin
      if (i != 0) cyc();
      n_vec++; if (ram_wr !== 1'b1) begin n_err++; $display("FAIL blk_drain_wr[%0d] got %b want 1", i, ram_wr); end
      n_vec++; if (ram_addr !== 16'(16'h1000 + i)) begin n_err++; $display("FAIL blk_drain_addr[%0d] got %h want %h", i, ram_addr, 16'(16'h1000 + i)); end
      n_vec++; if (ram_din !== 8'(8'h10 + i)) begin n_err++; $display("FAIL blk_drain_din[%0d] got %h want %h", i, ram_din, 8'(8'h10 + i)); end
    end
    cyc();
    dl_active = 1'b0;
    #1;
    n_vec++; if (ram_wr !== 1'b0) begin n_err++; $display("FAIL blk_done_wr got %b want 0", ram_wr); end
    n_vec++; if (dl_count !== 16'h0004) begin n_err++; $display("FAIL blk_count got %h want 0004", dl_count); end
    repeat (5) cyc();
    n_vec++; if (cpu_hold !== 1'b0) begin n_err++; $display("FAIL blk_idle_hold got %b want 0", cpu_hold); end
    n_vec++; if (dl_overflow !== 1'b1) begin n_err++; $display("FAIL blk_ovf_sticky got %b want 1", dl_overflow); end
  endtask

  task automatic test_push_pop();
    cyc();
    dl_active = 1'b1; cpu_clken = 1'b0;
    cyc();
    dl_wr = 1'b1; dl_addr = 16'h2000; dl_data = 8'h00;
    #1;
    n_vec++; if (dl_overflow !== 1'b0) begin n_err++; $display("FAIL pp_ovf_clr got %b want 0", dl_overflow); end
    n_vec++; if (ram_wr !== 1'b0) begin n_err++; $display("FAIL pp_first_wr got %b want 0", ram_wr); end
    for (int k = 1; k <= 6; k++) begin
      cyc();
      dl_addr = 16'(16'h2000 + k); dl_data = 8'(k);
      #1;
      n_vec++; if (ram_wr !== 1'b1) begin n_err++; $display("FAIL pp_wr[%0d] got %b want 1", k, ram_wr); end
      n_vec++; if (ram_addr !== 16'(16'h2000 + k - 1)) begin n_err++; $display("FAIL pp_addr[%0d] got %h want %h", k, ram_addr, 16'(16'h2000 + k - 1)); end
      n_vec++; if (ram_din !== 8'(k - 1)) begin n_err++; $display("FAIL pp_din[%0d] got %h want %h", k, ram_din, 8'(k - 1)); end
      n_vec++; if (dl_ready !== 1'b1) begin n_err++; $display("FAIL pp_ready[%0d] got %b want 1", k, dl_ready); end
      n_vec++; if (dl_count !== 16'(k - 1)) begin n_err++; $display("FAIL pp_count[%0d] got %h want %h", k, dl_count, 16'(k - 1)); end
    end
    cyc();
    dl_wr = 1'b0; dl_active = 1'b0;
    #1;
    n_vec++; if (ram_addr !== 16'h2006) begin n_err++; $display("FAIL pp_last_addr got %h want 2006", ram_addr); end
    n_vec++; if (dl_overflow !== 1'b0) begin n_err++; $display("FAIL pp_ovf got %b want 0", dl_overflow); end
    cyc();
    n_vec++; if (dl_count !== 16'h0007) begin n_err++; $display("FAIL pp_count_end got %h want 0007", dl_count); end
    n_vec++; if (ram_wr !== 1'b0) begin n_err++; $display("FAIL pp_end_wr got %b want 0", ram_wr); end
    repeat (4) cyc();
    n_vec++; if (cpu_hold !== 1'b0) begin n_err++; $display("FAIL pp_idle_hold got %b want 0", cpu_hold); end
    dl_wr = 1'b1;
    cyc();
    dl_wr = 1'b0;
    #1;
    n_vec++; if (dl_overflow !== 1'b0) begin n_err++; $display("FAIL pp_idle_push_ovf got %b want 0", dl_overflow); end
    n_vec++; if (dl_ready !== 1'b0) begin n_err++; $display("FAIL pp_idle_ready got %b want 0", dl_ready); end
  endtask

  task automatic test_reentry();
    cyc();
    dl_active = 1'b1; cpu_clken = 1'b0;
    cyc();
    dl_wr = 1'b1; dl_addr = 16'h3000; dl_data = 8'h77;
    cyc();
    dl_wr = 1'b0;
    #1;
    n_vec++; if (ram_addr !== 16'h3000) begin n_err++; $display("FAIL re_addr got %h want 3000", ram_addr); end
    cyc();
    dl_active = 1'b0;
    #1;
    n_vec++; if (dl_count !== 16'h0001) begin n_err++; $display("FAIL re_count got %h want 0001", dl_count); end
    cyc();
    n_vec++; if (cpu_hold !== 1'b1) begin n_err++; $display("FAIL re_rel1_hold got %b want 1", cpu_hold); end
    cyc();
    dl_active = 1'b1;
    #1;
    n_vec++; if (cpu_hold !== 1'b1) begin n_err++; $display("FAIL re_rel2_hold got %b want 1", cpu_hold); end
    cyc();
    n_vec++; if (cpu_hold !== 1'b1) begin n_err++; $display("FAIL re_load_hold got %b want 1", cpu_hold); end
    n_vec++; if (dl_ready !== 1'b1) begin n_err++; $display("FAIL re_load_ready got %b want 1", dl_ready); end
    n_vec++; if (dl_count !== 16'h0001) begin n_err++; $display("FAIL re_count_kept got %h want 0001", dl_count); end
    dl_wr = 1'b1; dl_addr = 16'h3001; dl_data = 8'h78;
    cyc();
    dl_wr = 1'b0;
    #1;
    n_vec++; if (ram_addr !== 16'h3001) begin n_err++; $display("FAIL re_addr2 got %h want 3001", ram_addr); end
    cyc();
    n_vec++; if (dl_count !== 16'h0002) begin n_err++; $display("FAIL re_count2 got %h want 0002", dl_count); end
  endtask

  task automatic test_async_reset();
    cpu_clken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      dl_wr = 1'b1; dl_addr = 16'(16'h4000 + i); dl_data = 8'(i);
      #1;
      n_vec++; if (ram_wr !== 1'b0) begin n_err++; $display("FAIL ar_push_wr[%0d] got %b want 0", i, ram_wr); end
    end
    cyc();
    dl_wr = 1'b0;
    #1;
    n_vec++; if (dl_count !== 16'h0002) begin n_err++; $display("FAIL ar_pre_count got %h want 0002", dl_count); end
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (cpu_hold !== 1'b0) begin n_err++; $display("FAIL ar_hold got %b want 0", cpu_hold); end
    n_vec++; if (dl_count !== 16'h0000) begin n_err++; $display("FAIL ar_count got %h want 0000", dl_count); end
    n_vec++; if (dl_ready !== 1'b0) begin n_err++; $display("FAIL ar_ready got %b want 0", dl_ready); end
    cyc();
    dl_active = 1'b0; cpu_clken = 1'b0; rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      n_vec++; if (ram_wr !== 1'b0) begin n_err++; $display("FAIL ar_no_wr[%0d] got %b want 0", i, ram_wr); end
      n_vec++; if (cpu_hold !== 1'b0) begin n_err++; $display("FAIL ar_idle[%0d] got %b want 0", i, cpu_hold); end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_single_byte();
    test_slot_blocking();
    test_push_pop();
    test_reentry();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
